// File: rtl/cache_axi_arbiter.sv
// Shares one AXI master between ICache reads and DCache reads/write-backs, stalling DCache reads that hit the pending write's line.
// Optional: define CACHE_ARB_RR_EN for round-robin read arbitration (default build uses fixed DCache priority).
module cache_axi_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int LINE_OFF = 5,
   parameter int LEN_W    = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              ic_rreq,
   input  logic [ADDR_W-1:0] ic_raddr,
   input  logic [LEN_W-1:0]  ic_rlen,
   output logic              ic_rvalid,
   output logic              ic_rlast,
   input  logic              dc_rreq,
   input  logic [ADDR_W-1:0] dc_raddr,
   input  logic [LEN_W-1:0]  dc_rlen,
   output logic              dc_rvalid,
   output logic              dc_rlast,
   input  logic              dc_wreq,
   input  logic [ADDR_W-1:0] dc_waddr,
   output logic              dc_wack,
   output logic [DATA_W-1:0] r_data,
   output logic              m_rreq,
   output logic [ADDR_W-1:0] m_raddr,
   output logic [LEN_W-1:0]  m_rlen,
   input  logic              m_rack,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_rvalid,
   input  logic              m_rlast,
   output logic              m_wreq,
   input  logic              m_wack,
   input  logic              m_wdone,
   output logic              arb_busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_I_REQ  = 3'd1,
      S_I_DATA = 3'd2,
      S_D_REQ  = 3'd3,
      S_D_DATA = 3'd4
   } state_t;

   state_t                     state, state_nxt;
   logic                       wr_pend;
   logic [ADDR_W-LINE_OFF-1:0] wr_line_q;
   logic                       dc_hz, dc_ok, grant_d, grant_i;

   // Write path: only one write outstanding; the next waits for its B response.
   assign m_wreq  = dc_wreq & ~wr_pend;
   assign dc_wack = m_wreq & m_wack;

   // A write accepted this cycle is already a hazard for a same-line read.
   assign dc_hz = (wr_pend & (dc_raddr[ADDR_W-1:LINE_OFF] == wr_line_q)) |
                  (dc_wack & (dc_raddr[ADDR_W-1:LINE_OFF] == dc_waddr[ADDR_W-1:LINE_OFF]));
   assign dc_ok = dc_rreq & ~dc_hz;

`ifdef CACHE_ARB_RR_EN
   logic last_grant;   // 1 = DCache was granted last

   assign grant_d = dc_ok & ~(ic_rreq & last_grant);

   always_ff @(posedge clk) begin
      if (!resetn)
         last_grant <= 1'b0;
      else if (state == S_IDLE && (grant_d || grant_i))
         last_grant <= grant_d;
   end
`else
   assign grant_d = dc_ok;
`endif

   assign grant_i = ic_rreq & ~grant_d;

   always_ff @(posedge clk) begin
      if (!resetn)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (grant_d)
               state_nxt = S_D_REQ;
            else if (grant_i)
               state_nxt = S_I_REQ;
         end
         S_I_REQ:  if (m_rack) state_nxt = S_I_DATA;
         S_D_REQ:  if (m_rack) state_nxt = S_D_DATA;
         S_I_DATA: if (m_rvalid && m_rlast) state_nxt = S_IDLE;
         S_D_DATA: if (m_rvalid && m_rlast) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      m_rreq    = 1'b0;
      ic_rvalid = 1'b0;
      ic_rlast  = 1'b0;
      dc_rvalid = 1'b0;
      dc_rlast  = 1'b0;
      arb_busy  = (state != S_IDLE);
      case (state)
         S_I_REQ, S_D_REQ: m_rreq = 1'b1;
         S_I_DATA: begin
            ic_rvalid = m_rvalid;
            ic_rlast  = m_rvalid & m_rlast;
         end
         S_D_DATA: begin
            dc_rvalid = m_rvalid;
            dc_rlast  = m_rvalid & m_rlast;
         end
         default: ;
      endcase
   end

   assign r_data = m_rdata;

   // Request address/length are captured once, on the grant out of IDLE.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         m_raddr <= '0;
         m_rlen  <= '0;
      end else if (state == S_IDLE) begin
         if (grant_d) begin
            m_raddr <= dc_raddr;
            m_rlen  <= dc_rlen;
         end else if (grant_i) begin
            m_raddr <= ic_raddr;
            m_rlen  <= ic_rlen;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_pend   <= 1'b0;
         wr_line_q <= '0;
      end else if (dc_wack) begin
         wr_pend   <= 1'b1;
         wr_line_q <= dc_waddr[ADDR_W-1:LINE_OFF];
      end else if (m_wdone) begin
         wr_pend   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed self-checking bench for cache_axi_arbiter; inputs change 1 ns after the rising edge, outputs are checked on the falling edge.
module tb_cache_axi_arbiter;

   localparam int ADDR_W   = 32;
   localparam int DATA_W   = 32;
   localparam int LINE_OFF = 5;
   localparam int LEN_W    = 8;

   logic              clk = 1'b0;
   logic              resetn;
   logic              ic_rreq, dc_rreq, dc_wreq;
   logic [ADDR_W-1:0] ic_raddr, dc_raddr, dc_waddr;
   logic [LEN_W-1:0]  ic_rlen, dc_rlen;
   logic              ic_rvalid, ic_rlast, dc_rvalid, dc_rlast, dc_wack;
   logic [DATA_W-1:0] r_data, m_rdata;
   logic              m_rreq, m_rack, m_rvalid, m_rlast;
   logic [ADDR_W-1:0] m_raddr;
   logic [LEN_W-1:0]  m_rlen;
   logic              m_wreq, m_wack, m_wdone, arb_busy;

   int                n_chk  = 0;
   int                n_fail = 0;
   logic [31:0]       exp_q[$];

   cache_axi_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_OFF(LINE_OFF), .LEN_W(LEN_W)
   ) dut (
      .clk(clk), .resetn(resetn),
      .ic_rreq(ic_rreq), .ic_raddr(ic_raddr), .ic_rlen(ic_rlen),
      .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast),
      .dc_rreq(dc_rreq), .dc_raddr(dc_raddr), .dc_rlen(dc_rlen),
      .dc_rvalid(dc_rvalid), .dc_rlast(dc_rlast),
      .dc_wreq(dc_wreq), .dc_waddr(dc_waddr), .dc_wack(dc_wack),
      .r_data(r_data),
      .m_rreq(m_rreq), .m_raddr(m_raddr), .m_rlen(m_rlen), .m_rack(m_rack),
      .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
      .m_wreq(m_wreq), .m_wack(m_wack), .m_wdone(m_wdone),
      .arb_busy(arb_busy)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      check({tag, "_m_rreq"},    32'(m_rreq),    32'd0);
      check({tag, "_m_wreq"},    32'(m_wreq),    32'd0);
      check({tag, "_ic_rvalid"}, 32'(ic_rvalid), 32'd0);
      check({tag, "_ic_rlast"},  32'(ic_rlast),  32'd0);
      check({tag, "_dc_rvalid"}, 32'(dc_rvalid), 32'd0);
      check({tag, "_dc_rlast"},  32'(dc_rlast),  32'd0);
      check({tag, "_dc_wack"},   32'(dc_wack),   32'd0);
      check({tag, "_arb_busy"},  32'(arb_busy),  32'd0);
      check({tag, "_m_raddr"},   m_raddr,        32'd0);
      check({tag, "_m_rlen"},    32'(m_rlen),    32'd0);
      check({tag, "_r_data"},    r_data,         32'd0);
   endtask

   // Entered with the winner's request already driven in an IDLE cycle; leaves in the following IDLE cycle.
   task automatic serve(input bit is_d, input logic [31:0] addr, input logic [7:0] len);
      int nb;
      nb = int'(len) + 1;
      @(negedge clk);
      check("grant_idle_busy", 32'(arb_busy), 32'd0);
      tick();
      @(negedge clk);
      check("req_m_rreq",   32'(m_rreq),   32'd1);
      check("req_m_raddr",  m_raddr,       addr);
      check("req_m_rlen",   32'(m_rlen),   32'(len));
      check("req_arb_busy", 32'(arb_busy), 32'd1);
      tick();
      m_rack = 1'b1;
      @(negedge clk);
      check("rack_m_rreq", 32'(m_rreq), 32'd1);
      tick();
      m_rack = 1'b0;
      for (int i = 0; i < nb; i++) exp_q.push_back(addr + 32'(i * 4));
      for (int i = 0; i < nb; i++) begin
         m_rvalid = 1'b1;
         m_rdata  = addr + 32'(i * 4);
         m_rlast  = (i == nb - 1);
         @(negedge clk);
         check("beat_m_rreq", 32'(m_rreq), 32'd0);
         check("beat_own_rvalid",   32'(is_d ? dc_rvalid : ic_rvalid), 32'd1);
         check("beat_other_rvalid", 32'(is_d ? ic_rvalid : dc_rvalid), 32'd0);
         check("beat_own_rlast",    32'(is_d ? dc_rlast  : ic_rlast),  32'(i == nb - 1));
         check("beat_r_data", r_data, exp_q.pop_front());
         tick();
      end
      m_rvalid = 1'b0;
      m_rlast  = 1'b0;
      m_rdata  = '0;
      if (is_d) dc_rreq = 1'b0;
      else      ic_rreq = 1'b0;
   endtask

   initial begin
      resetn  = 1'b0;
      ic_rreq = 1'b0; ic_raddr = '0; ic_rlen = '0;
      dc_rreq = 1'b0; dc_raddr = '0; dc_rlen = '0;
      dc_wreq = 1'b0; dc_waddr = '0;
      m_rack  = 1'b0; m_rdata = '0; m_rvalid = 1'b0; m_rlast = 1'b0;
      m_wack  = 1'b0; m_wdone = 1'b0;
      repeat (2) tick();
      check_reset_outputs("reset");
      tick();
      resetn = 1'b1;

      // ICache-only 8-beat burst
      ic_rreq = 1'b1; ic_raddr = 32'h1FC0_0000; ic_rlen = 8'd7;
      serve(1'b0, 32'h1FC0_0000, 8'd7);
      @(negedge clk);
      check("ic_done_busy", 32'(arb_busy), 32'd0);
      tick();

      // DCache-only single beat so the last grant is DCache, then both at once
      dc_rreq = 1'b1; dc_raddr = 32'h0000_0100; dc_rlen = 8'd0;
      serve(1'b1, 32'h0000_0100, 8'd0);
      ic_rreq = 1'b1; ic_raddr = 32'h1FC0_0020; ic_rlen = 8'd3;
      dc_rreq = 1'b1; dc_raddr = 32'h0000_0200; dc_rlen = 8'd1;
`ifdef CACHE_ARB_RR_EN
      serve(1'b0, 32'h1FC0_0020, 8'd3);
      serve(1'b1, 32'h0000_0200, 8'd1);
`else
      serve(1'b1, 32'h0000_0200, 8'd1);
      serve(1'b0, 32'h1FC0_0020, 8'd3);
`endif

      // Write accepted together with a same-line read: read held until after m_wdone
      dc_wreq = 1'b1; dc_waddr = 32'h8000_1040; m_wack = 1'b1;
      dc_rreq = 1'b1; dc_raddr = 32'h8000_1044; dc_rlen = 8'd3;
      @(negedge clk);
      check("hz_m_wreq",   32'(m_wreq),   32'd1);
      check("hz_dc_wack",  32'(dc_wack),  32'd1);
      check("hz_busy_acc", 32'(arb_busy), 32'd0);
      tick();
      dc_wreq = 1'b0; m_wack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hz_stall_busy",   32'(arb_busy), 32'd0);
         check("hz_stall_m_rreq", 32'(m_rreq),   32'd0);
         tick();
      end
      m_wdone = 1'b1;
      @(negedge clk);
      check("hz_wdone_busy", 32'(arb_busy), 32'd0);
      tick();
      m_wdone = 1'b0;
      serve(1'b1, 32'h8000_1044, 8'd3);

      // Pending write on 0x80001040 does not block a read of another line
      dc_wreq = 1'b1; dc_waddr = 32'h8000_1040; m_wack = 1'b1;
      @(negedge clk);
      check("nohz_dc_wack", 32'(dc_wack), 32'd1);
      tick();
      dc_wreq = 1'b0; m_wack = 1'b0;
      dc_rreq = 1'b1; dc_raddr = 32'h8000_2000; dc_rlen = 8'd1;
      serve(1'b1, 32'h8000_2000, 8'd1);

      // Second write held while the first is still pending
      dc_wreq = 1'b1; dc_waddr = 32'h8000_3000; m_wack = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("w2_hold_m_wreq",  32'(m_wreq),  32'd0);
         check("w2_hold_dc_wack", 32'(dc_wack), 32'd0);
         tick();
      end
      m_wdone = 1'b1;
      @(negedge clk);
      check("w2_wdone_m_wreq", 32'(m_wreq), 32'd0);
      tick();
      m_wdone = 1'b0;
      @(negedge clk);
      check("w2_acc_m_wreq",  32'(m_wreq),  32'd1);
      check("w2_acc_dc_wack", 32'(dc_wack), 32'd1);
      tick();
      dc_wreq = 1'b0; m_wack = 1'b0;

      // Stray beat in IDLE is dropped
      m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("stray_ic_rvalid", 32'(ic_rvalid), 32'd0);
      check("stray_dc_rvalid", 32'(dc_rvalid), 32'd0);
      check("stray_ic_rlast",  32'(ic_rlast),  32'd0);
      check("stray_dc_rlast",  32'(dc_rlast),  32'd0);
      check("stray_r_data",    r_data,         32'hDEAD_BEEF);
      check("stray_busy",      32'(arb_busy),  32'd0);
      tick();
      m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0;

      // Reset during the third beat of an ICache burst (a write is still pending)
      ic_rreq = 1'b1; ic_raddr = 32'h1FC0_0100; ic_rlen = 8'd7;
      tick();
      tick();
      m_rack = 1'b1;
      tick();
      m_rack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m_rvalid = 1'b1;
         m_rdata  = 32'h1FC0_0100 + 32'(i * 4);
         if (i == 2) resetn = 1'b0;
         @(negedge clk);
         check("rst_beat_ic_rvalid", 32'(ic_rvalid), 32'd1);
         tick();
      end
      ic_rreq = 1'b0; m_rdata = '0;
      check_reset_outputs("rst_mid");
      tick();
      resetn = 1'b1; m_rvalid = 1'b0;
      dc_wreq = 1'b1; dc_waddr = 32'h8000_3000;
      @(negedge clk);
      check("rst_wr_pend_clear", 32'(m_wreq), 32'd1);
      tick();
      dc_wreq = 1'b0;
      ic_rreq = 1'b1; ic_raddr = 32'h1FC0_0000; ic_rlen = 8'd1;
      serve(1'b0, 32'h1FC0_0000, 8'd1);
      @(negedge clk);
      check("final_busy", 32'(arb_busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
